// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: Montgomery modular exponentiation, o_a_pow_d = a^d mod n, one operation at a time.
// Latency: o_finished 1+WIDTH+WIDTH*(WIDTH+1) edges after the accepting edge (shorter with RSA_EARLY_EXIT_EN).
// Backpressure: none; i_start is only sampled in S_IDLE, so requests while busy are dropped.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_start               start request, accepted only when idle
//   i_a, i_d, i_n         base (< n), exponent, odd modulus; captured on the accepting edge
//   o_a_pow_d             result, held until the next completion
//   o_finished            one-cycle completion pulse (first idle cycle)
//   o_busy                high while an operation is in flight
// Optional build macro: RSA_EARLY_EXIT_EN stops once no set exponent bits remain above i.
module rsa_modexp_core #(
   parameter int WIDTH = 256,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_d,
   input  logic [WIDTH-1:0] i_n,
   output logic [WIDTH-1:0] o_a_pow_d,
   output logic             o_finished,
   output logic             o_busy
);

   // Two guard bits: t doubles before reduction and Montgomery sums reach < 4n.
   localparam int AW = WIDTH + 2;
   localparam logic [CNT_W-1:0] PREP_LAST = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_MONT, S_CALC} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d_q, n_q, m_q;
   logic [AW-1:0]    t_q, acc_m_q, acc_t_q;
   logic [CNT_W-1:0] cnt_q, idx_q;

   logic [AW-1:0]    n_ext, t_prep, acc_m_nxt, acc_t_nxt;
   logic [WIDTH-1:0] m_next, t_next, result_d;
   logic             d_bit, finish_d;

   function automatic logic bit_at(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] k);
      logic b;
      b = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
         if (k == CNT_W'(j)) b = v[j];
      end
      return b;
   endfunction

   // One radix-2 Montgomery step: add y if the multiplier bit is set, make even with n, halve.
   function automatic logic [AW-1:0] mont_step(input logic [AW-1:0] acc, input logic xb,
                                               input logic [AW-1:0] y, input logic [AW-1:0] n);
      logic [AW-1:0] s;
      s = acc + (xb ? y : '0);
      if (s[0]) s = s + n;
      return s >> 1;
   endfunction

   function automatic logic [WIDTH-1:0] reduce(input logic [AW-1:0] x, input logic [AW-1:0] n);
      return WIDTH'((x >= n) ? x - n : x);
   endfunction

   assign n_ext     = {2'b00, n_q};
   assign t_prep    = ((t_q << 1) >= n_ext) ? (t_q << 1) - n_ext : (t_q << 1);
   // m stays in the normal domain because t carries the Montgomery factor R.
   assign acc_m_nxt = mont_step(acc_m_q, bit_at(m_q, cnt_q), t_q, n_ext);
   assign acc_t_nxt = mont_step(acc_t_q, bit_at(t_q[WIDTH-1:0], cnt_q), t_q, n_ext);
   assign d_bit     = bit_at(d_q, idx_q);
   assign m_next    = d_bit ? reduce(acc_m_q, n_ext) : m_q;
   assign t_next    = reduce(acc_t_q, n_ext);
   // Only S_CALC commits m; the other finishing path is d == 0, whose result is 1.
   assign result_d  = (state_q == S_CALC) ? m_next : WIDTH'(1);
   assign o_busy    = (state_q != S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      finish_d = 1'b0;
      case (state_q)
         S_IDLE: if (i_start) state_d = S_PREP;
         S_PREP: begin
            // WIDTH doubling cycles followed by one hand-over cycle.
            if (cnt_q == PREP_LAST) begin
`ifdef RSA_EARLY_EXIT_EN
               if (d_q == '0) begin
                  state_d  = S_IDLE;
                  finish_d = 1'b1;
               end else begin
                  state_d = S_MONT;
               end
`else
               state_d = S_MONT;
`endif
            end
         end
         S_MONT: if (cnt_q == BIT_LAST) state_d = S_CALC;
         S_CALC: begin
`ifdef RSA_EARLY_EXIT_EN
            if ((idx_q == BIT_LAST) || (((d_q >> idx_q) >> 1) == '0)) begin
`else
            if (idx_q == BIT_LAST) begin
`endif
               state_d  = S_IDLE;
               finish_d = 1'b1;
            end else begin
               state_d = S_MONT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         d_q        <= '0;
         n_q        <= '0;
         m_q        <= '0;
         t_q        <= '0;
         acc_m_q    <= '0;
         acc_t_q    <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         o_a_pow_d  <= '0;
         o_finished <= 1'b0;
      end else begin
         o_finished <= finish_d;
         if (finish_d) o_a_pow_d <= result_d;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  d_q     <= i_d;
                  n_q     <= i_n;
                  t_q     <= {2'b00, i_a};
                  m_q     <= WIDTH'(1);
                  acc_m_q <= '0;
                  acc_t_q <= '0;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end
            end
            S_PREP: begin
               if (cnt_q == PREP_LAST) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  acc_m_q <= '0;
                  acc_t_q <= '0;
               end else begin
                  t_q   <= t_prep;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_MONT: begin
               acc_m_q <= acc_m_nxt;
               acc_t_q <= acc_t_nxt;
               cnt_q   <= cnt_q + 1'b1;
            end
            S_CALC: begin
               m_q     <= m_next;
               t_q     <= {2'b00, t_next};
               idx_q   <= idx_q + 1'b1;
               cnt_q   <= '0;
               acc_m_q <= '0;
               acc_t_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: directed vectors for an 8-bit rsa_modexp_core.
// Checks reset state, results, completion latency, busy/finished timing,
// start-while-busy rejection, mid-operation reset and back-to-back starts.
module tb_rsa_modexp_core;

   localparam int W = 8;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic [W-1:0] i_a = '0;
   logic [W-1:0] i_d = '0;
   logic [W-1:0] i_n = '0;
   logic [W-1:0] o_a_pow_d;
   logic         o_finished;
   logic         o_busy;

   int n_cmp = 0;
   int n_err = 0;

   rsa_modexp_core #(.WIDTH(W)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_a        (i_a),
      .i_d        (i_d),
      .i_n        (i_n),
      .o_a_pow_d  (o_a_pow_d),
      .o_finished (o_finished),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Completion edge count after the accepting edge, straight from the latency formula.
   function automatic int exp_lat(input logic [W-1:0] d);
`ifdef RSA_EARLY_EXIT_EN
      int msb;
      if (d == '0) return 1 + W;
      msb = 0;
      for (int j = 0; j < W; j++) if (d[j]) msb = j;
      return 1 + W + (msb + 1) * (W + 1);
`else
      return 1 + W + W * (W + 1);
`endif
   endfunction

   // Called at a negedge; returns at the negedge of the o_finished cycle so a
   // following call issues its start in that same cycle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] n,
                        input logic [W-1:0] exp, input string tag, input bit poke);
      int cyc;
      bit done;
      i_a = a; i_d = d; i_n = n; i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      check({tag, "_busy_on"}, o_busy, 1);
      check({tag, "_fin_low"}, o_finished, 0);
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 200) begin
         @(posedge i_clk);
         cyc++;
         @(negedge i_clk);
         if (poke && cyc == 10) begin
            i_start = 1'b1; i_a = 8'd7; i_d = 8'd4; i_n = 8'd13;
         end
         if (poke && cyc == 12) check({tag, "_busy_poke"}, o_busy, 1);
         if (poke && cyc == 13) i_start = 1'b0;
         done = o_finished;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_lat"}, cyc, exp_lat(d));
      check({tag, "_res"}, o_a_pow_d, exp);
      check({tag, "_busy_off"}, o_busy, 0);
   endtask

   task automatic gap(input logic [W-1:0] exp, input string tag);
      @(negedge i_clk);
      check({tag, "_pulse1"}, o_finished, 0);
      @(negedge i_clk);
      check({tag, "_hold"}, o_a_pow_d, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge i_clk);
      check("rst_fin", o_finished, 0);
      check("rst_busy", o_busy, 0);
      check("rst_res", o_a_pow_d, 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      do_op(8'd5,   8'd3, 8'd187, 8'd125, "t1", 1'b0); gap(8'd125, "t1");
      do_op(8'd100, 8'd0, 8'd187, 8'd1,   "t2", 1'b0); gap(8'd1,   "t2");
      do_op(8'd0,   8'd7, 8'd187, 8'd0,   "t3a", 1'b0); gap(8'd0,  "t3a");
      do_op(8'd186, 8'd2, 8'd187, 8'd1,   "t3b", 1'b0);

      // Back-to-back: each start is issued in the previous o_finished cycle.
      do_op(8'd2,   8'd8,   8'd187, 8'd69,  "b1", 1'b0);
      do_op(8'd3,   8'd5,   8'd187, 8'd56,  "b2", 1'b0);
      do_op(8'd7,   8'd4,   8'd187, 8'd157, "b3", 1'b0);
      do_op(8'd2,   8'd5,   8'd13,  8'd6,   "b4", 1'b0);
      do_op(8'd2,   8'd1,   8'd3,   8'd2,   "b5", 1'b0);
      do_op(8'd254, 8'd1,   8'd255, 8'd254, "b6", 1'b0);
      do_op(8'd3,   8'd250, 8'd251, 8'd1,   "b7", 1'b0);
      do_op(8'd186, 8'd3,   8'd187, 8'd186, "b8", 1'b0);
      do_op(8'd1,   8'd128, 8'd187, 8'd1,   "b9", 1'b0); gap(8'd1, "b9");

      // Start requests while busy must be ignored.
      do_op(8'd5, 8'd3, 8'd187, 8'd125, "t4", 1'b1); gap(8'd125, "t4");

      // Reset in the middle of S_MONT.
      i_a = 8'd5; i_d = 8'd3; i_n = 8'd187; i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (14) @(negedge i_clk);
      check("t5_busy_pre", o_busy, 1);
      i_rst_n = 1'b0;
      #1;
      check("t5_rst_fin", o_finished, 0);
      check("t5_rst_busy", o_busy, 0);
      check("t5_rst_res", o_a_pow_d, 0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("t5_idle_busy", o_busy, 0);
      do_op(8'd10, 8'd2, 8'd187, 8'd100, "t5", 1'b0); gap(8'd100, "t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
